// File: rtl/seg7_accel_display.sv
// Accelerometer byte display: captures bytes from the SPI controller, converts them to decimal
// with a serial double-dabble FSM and scans a 4-digit common-anode 7-segment display.
module seg7_accel_display #(
  parameter int unsigned REFRESH_DIVIDE = 31250,
  parameter bit          SIGNED_MODE    = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] DATA_IN,
  input  logic       DATA_VALID,
  output logic [6:0] SEG,
  output logic [3:0] AN,
  output logic       DP,
  output logic       BUSY,
  output logic       UPDATED
);

  localparam int unsigned      CNT_W     = (REFRESH_DIVIDE > 1) ? $clog2(REFRESH_DIVIDE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIVIDE - 1);
  localparam logic [6:0]       SEG_BLANK = 7'h7F;
  localparam logic [6:0]       SEG_MINUS = 7'h3F;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_LOAD
  } state_t;

  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int_n;

  state_t           state_q, state_d;
  logic             dv_q, dv_d;
  logic             sign_q, sign_d;
  logic [7:0]       mag_q, mag_d;
  logic [11:0]      bcd_q, bcd_d;
  logic [3:0]       iter_q, iter_d;
  logic             pend_flag_q, pend_flag_d;
  logic [7:0]       pend_byte_q, pend_byte_d;
  logic             disp_sign_q, disp_sign_d;
  logic [11:0]      disp_bcd_q, disp_bcd_d;
  logic             updated_q, updated_d;
  logic [CNT_W-1:0] refresh_q, refresh_d;
  logic [1:0]       scan_q, scan_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;

  logic        capture;
  logic        start;
  logic [7:0]  start_byte;
  logic [11:0] bcd_adj;
  logic [19:0] shifted;
  logic        wrap;
  logic [6:0]  slot_seg;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Returns {sign, magnitude}; 0x80 negates to 0x80, which reads correctly as 128 unsigned.
  function automatic logic [8:0] split_byte(input logic [7:0] b);
    logic [7:0] neg;
    neg = ~b + 8'd1;
    if (SIGNED_MODE && b[7]) return {1'b1, neg};
    else return {1'b0, b};
  endfunction

  // Release of the external reset is re-timed to CLK so every flop leaves reset together.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) rst_sync_q <= 2'b00;
    else          rst_sync_q <= rst_sync_d;
  end

  assign rst_int_n = rst_sync_q[1];

  always_comb begin
    state_d     = state_q;
    dv_d        = DATA_VALID;
    sign_d      = sign_q;
    mag_d       = mag_q;
    bcd_d       = bcd_q;
    iter_d      = iter_q;
    pend_flag_d = pend_flag_q;
    pend_byte_d = pend_byte_q;
    disp_sign_d = disp_sign_q;
    disp_bcd_d  = disp_bcd_q;
    updated_d   = 1'b0;
    capture     = DATA_VALID & ~dv_q;
    start       = 1'b0;
    start_byte  = DATA_IN;
    bcd_adj     = bcd_q;
    shifted     = '0;

    case (state_q)
      S_IDLE: begin
        if (capture) begin
          start      = 1'b1;
          start_byte = DATA_IN;
        end else if (pend_flag_q) begin
          start       = 1'b1;
          start_byte  = pend_byte_q;
          pend_flag_d = 1'b0;
        end
      end
      S_CONVERT: begin
        for (int i = 0; i < 3; i++) begin
          if (bcd_adj[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_adj[i*4 +: 4] + 4'd3;
        end
        shifted = {bcd_adj, mag_q} << 1;
        bcd_d   = shifted[19:8];
        mag_d   = shifted[7:0];
        iter_d  = iter_q - 4'd1;
        if (iter_q == 4'd1) state_d = S_LOAD;
        if (capture) begin
          pend_flag_d = 1'b1;
          pend_byte_d = DATA_IN;
        end
      end
      S_LOAD: begin
        updated_d   = 1'b1;
        disp_sign_d = sign_q;
        disp_bcd_d  = bcd_q;
        state_d     = S_IDLE;
        if (pend_flag_q) begin
          start       = 1'b1;
          start_byte  = pend_byte_q;
          pend_flag_d = 1'b0;
        end
        // A byte arriving while the old pending one is consumed becomes the next pending byte.
        if (capture) begin
          pend_flag_d = 1'b1;
          pend_byte_d = DATA_IN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      {sign_d, mag_d} = split_byte(start_byte);
      bcd_d           = '0;
      iter_d          = 4'd8;
      state_d         = S_CONVERT;
    end
  end

  always_comb begin
    wrap      = (refresh_q == CNT_LAST);
    refresh_d = wrap ? '0 : refresh_q + 1'b1;
    scan_d    = scan_q;
    an_d      = an_q;
    seg_d     = seg_q;
    case (scan_q)
      2'd0:    slot_seg = digit_seg(disp_bcd_q[3:0]);
      2'd1:    slot_seg = (disp_bcd_q[11:4] == 8'd0) ? SEG_BLANK : digit_seg(disp_bcd_q[7:4]);
      2'd2:    slot_seg = (disp_bcd_q[11:8] == 4'd0) ? SEG_BLANK : digit_seg(disp_bcd_q[11:8]);
      default: slot_seg = (SIGNED_MODE && disp_sign_q) ? SEG_MINUS : SEG_BLANK;
    endcase
    if (wrap) begin
      scan_d = scan_q + 2'd1;
      an_d   = ~(4'b0001 << scan_q);
      seg_d  = slot_seg;
    end
  end

  always_ff @(posedge CLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= S_IDLE;
      dv_q        <= 1'b0;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      bcd_q       <= '0;
      iter_q      <= '0;
      pend_flag_q <= 1'b0;
      pend_byte_q <= '0;
      disp_sign_q <= 1'b0;
      disp_bcd_q  <= '0;
      updated_q   <= 1'b0;
      refresh_q   <= '0;
      scan_q      <= '0;
      seg_q       <= SEG_BLANK;
      an_q        <= 4'hF;
    end else begin
      state_q     <= state_d;
      dv_q        <= dv_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      bcd_q       <= bcd_d;
      iter_q      <= iter_d;
      pend_flag_q <= pend_flag_d;
      pend_byte_q <= pend_byte_d;
      disp_sign_q <= disp_sign_d;
      disp_bcd_q  <= disp_bcd_d;
      updated_q   <= updated_d;
      refresh_q   <= refresh_d;
      scan_q      <= scan_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign SEG     = seg_q;
  assign AN      = an_q;
  assign DP      = 1'b1;
  assign BUSY    = (state_q != S_IDLE);
  assign UPDATED = updated_q;

endmodule

// File: tb/tb_seg7_accel_display.sv
// Bench for seg7_accel_display: a signed and an unsigned instance share stimulus and are checked
// every cycle against a decimal-arithmetic model, plus literal display frames.
module tb_seg7_accel_display;

  localparam int DIV = 8;

  logic       CLK        = 1'b0;
  logic       RESET_N    = 1'b0;
  logic [7:0] DATA_IN    = 8'h00;
  logic       DATA_VALID = 1'b0;

  logic [6:0] segS, segU;
  logic [3:0] anS, anU;
  logic       dpS, dpU, busyS, busyU, updS, updU;

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;

  int         mRem, mRef, mWraps, relCnt;
  logic [7:0] mCur, mPendV, mDisp;
  bit         mPend, mDvh, mUpd;
  logic [3:0] mAn;
  logic [6:0] mSegS, mSegU;

  seg7_accel_display #(.REFRESH_DIVIDE(DIV), .SIGNED_MODE(1'b1)) dutS (
    .CLK(CLK), .RESET_N(RESET_N), .DATA_IN(DATA_IN), .DATA_VALID(DATA_VALID),
    .SEG(segS), .AN(anS), .DP(dpS), .BUSY(busyS), .UPDATED(updS)
  );

  seg7_accel_display #(.REFRESH_DIVIDE(DIV), .SIGNED_MODE(1'b0)) dutU (
    .CLK(CLK), .RESET_N(RESET_N), .DATA_IN(DATA_IN), .DATA_VALID(DATA_VALID),
    .SEG(segU), .AN(anU), .DP(dpU), .BUSY(busyU), .UPDATED(updU)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic valid);
    @(negedge CLK);
    DATA_IN    = data;
    DATA_VALID = valid;
  endtask

  function automatic logic [6:0] encDigit(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      default: return 7'h10;
    endcase
  endfunction

  // Digit pattern for display position pos (0 = rightmost) when byte b is shown.
  function automatic logic [6:0] expSeg(input logic [7:0] b, input int pos, input bit signedMode);
    int val, mag, h, t, u;
    val = signedMode ? int'($signed(b)) : int'(b);
    mag = (val < 0) ? -val : val;
    h = mag / 100;
    t = (mag / 10) % 10;
    u = mag % 10;
    case (pos)
      0: return encDigit(u);
      1: return (h == 0 && t == 0) ? 7'h7F : encDigit(t);
      2: return (h == 0) ? 7'h7F : encDigit(h);
      default: return (val < 0) ? 7'h3F : 7'h7F;
    endcase
  endfunction

  task automatic resetModel();
    mRem = 0; mRef = 0; mWraps = 0; relCnt = 0;
    mCur = 0; mPendV = 0; mDisp = 0;
    mPend = 0; mDvh = 0; mUpd = 0;
    mAn = 4'hF; mSegS = 7'h7F; mSegU = 7'h7F;
  endtask

  // One clock of the model: conversion takes 9 clocks from capture to display, one pending slot.
  task automatic modelStep();
    bit cap;
    int pos;
    if (mRef == DIV - 1) begin
      mRef  = 0;
      pos   = mWraps % 4;
      mAn   = ~(4'b0001 << pos);
      mSegS = expSeg(mDisp, pos, 1'b1);
      mSegU = expSeg(mDisp, pos, 1'b0);
      mWraps++;
    end else begin
      mRef++;
    end
    cap  = DATA_VALID && !mDvh;
    mDvh = DATA_VALID;
    mUpd = 0;
    if (mRem == 0) begin
      if (cap) begin
        mRem = 9; mCur = DATA_IN;
      end else if (mPend) begin
        mRem = 9; mCur = mPendV; mPend = 0;
      end
    end else if (mRem == 1) begin
      mUpd  = 1;
      mDisp = mCur;
      if (mPend) begin
        mRem = 9; mCur = mPendV; mPend = 0;
      end else begin
        mRem = 0;
      end
      if (cap) begin
        mPend = 1; mPendV = DATA_IN;
      end
    end else begin
      mRem--;
      if (cap) begin
        mPend = 1; mPendV = DATA_IN;
      end
    end
  endtask

  // Two clocks after reset release are still spent in reset while it is re-timed.
  initial begin
    resetModel();
    forever begin
      @(posedge CLK or negedge RESET_N);
      if (!RESET_N) resetModel();
      else if (relCnt < 2) relCnt++;
      else modelStep();
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      checkOutput("UPDATED signed", updS, mUpd);
      checkOutput("UPDATED unsigned", updU, mUpd);
      checkOutput("BUSY signed", busyS, (mRem != 0));
      checkOutput("BUSY unsigned", busyU, (mRem != 0));
      checkOutput("AN signed", anS, mAn);
      checkOutput("AN unsigned", anU, mAn);
      checkOutput("SEG signed", segS, mSegS);
      checkOutput("SEG unsigned", segU, mSegU);
      checkOutput("DP signed", dpS, 1'b1);
      checkOutput("DP unsigned", dpU, 1'b1);
    end
  end

  task automatic checkFrame(input string name, input logic [27:0] expS, input logic [27:0] expU);
    logic [6:0] gotS [4];
    logic [6:0] gotU [4];
    for (int p = 0; p < 4; p++) begin
      gotS[p] = 7'h00;
      gotU[p] = 7'h00;
    end
    repeat (5 * DIV) @(negedge CLK);
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge CLK);
      for (int p = 0; p < 4; p++) begin
        if (anS[p] == 1'b0) gotS[p] = segS;
        if (anU[p] == 1'b0) gotU[p] = segU;
      end
    end
    for (int p = 0; p < 4; p++) begin
      checkOutput($sformatf("%s signed AN%0d", name, p), gotS[p], expS[p*7 +: 7]);
      checkOutput($sformatf("%s unsigned AN%0d", name, p), gotU[p], expU[p*7 +: 7]);
    end
  endtask

  task automatic runCase(input string name, input logic [7:0] data, input int hold,
                         input logic [27:0] expS, input logic [27:0] expU);
    int capCyc, pulses, lat;
    applyStimulus(data, 1'b1);
    capCyc = cyc + 1;
    pulses = 0;
    lat    = -1;
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      if (updS) begin
        pulses++;
        if (lat < 0) lat = cyc - capCyc;
      end
    end
    DATA_VALID = 1'b0;
    checkOutput({name, " pulse count"}, pulses, 1);
    checkOutput({name, " latency"}, lat, 9);
    checkFrame(name, expS, expU);
  endtask

  initial begin
    int capCyc, pulses, firstCyc, secondCyc;

    repeat (3) @(negedge CLK);
    checkOutput("reset SEG", segS, 7'h7F);
    checkOutput("reset AN", anS, 4'hF);
    checkOutput("reset DP", dpS, 1'b1);
    checkOutput("reset BUSY", busyS, 1'b0);
    checkOutput("reset UPDATED", updS, 1'b0);
    #2 RESET_N = 1'b1;
    repeat (4) @(negedge CLK);
    checkOutput("AN before first wrap", anS, 4'hF);

    runCase("x85", 8'h85, 2000, {7'h3F, 7'h79, 7'h24, 7'h30}, {7'h7F, 7'h79, 7'h30, 7'h30});
    runCase("x80", 8'h80, 20,   {7'h3F, 7'h79, 7'h24, 7'h00}, {7'h7F, 7'h79, 7'h24, 7'h00});
    runCase("xFF", 8'hFF, 20,   {7'h3F, 7'h7F, 7'h7F, 7'h79}, {7'h7F, 7'h24, 7'h12, 7'h12});
    runCase("x07", 8'h07, 20,   {7'h7F, 7'h7F, 7'h7F, 7'h78}, {7'h7F, 7'h7F, 7'h7F, 7'h78});
    runCase("x00", 8'h00, 20,   {7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40});

    // Three captures in five clocks: the middle byte is overwritten before it is converted.
    applyStimulus(8'h0C, 1'b1);
    capCyc = cyc + 1;
    applyStimulus(8'h0C, 1'b0);
    applyStimulus(8'h22, 1'b1);
    applyStimulus(8'h22, 1'b0);
    applyStimulus(8'h63, 1'b1);
    pulses = 0; firstCyc = -1; secondCyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (updS) begin
        pulses++;
        if (firstCyc < 0) firstCyc = cyc;
        else if (secondCyc < 0) secondCyc = cyc;
      end
    end
    DATA_VALID = 1'b0;
    checkOutput("pending pulse count", pulses, 2);
    checkOutput("pending first latency", firstCyc - capCyc, 9);
    checkOutput("pending pulse spacing", secondCyc - firstCyc, 9);
    checkFrame("pending x63", {7'h7F, 7'h7F, 7'h10, 7'h10}, {7'h7F, 7'h7F, 7'h10, 7'h10});

    applyStimulus(8'h55, 1'b1);
    repeat (3) @(negedge CLK);
    checkOutput("BUSY before reset", busyS, 1'b1);
    #2 RESET_N = 1'b0;
    #1;
    checkOutput("mid-convert reset SEG", segS, 7'h7F);
    checkOutput("mid-convert reset AN", anS, 4'hF);
    checkOutput("mid-convert reset BUSY", busyS, 1'b0);
    checkOutput("mid-convert reset UPDATED", updS, 1'b0);
    DATA_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RESET_N = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (updS || updU) pulses++;
    end
    checkOutput("no UPDATED after reset", pulses, 0);
    runCase("x2A after reset", 8'h2A, 20, {7'h7F, 7'h7F, 7'h19, 7'h24}, {7'h7F, 7'h7F, 7'h19, 7'h24});

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/seg7_accel_display.md
Name: seg7_accel_display

Overview:
- Downstream consumer of the SPI controller's received accelerometer byte (MISO_DATA / DATA_VALID).
- Captures each new byte and converts it to decimal with an iterative double-dabble FSM.
- Drives a 4-digit, time-multiplexed, common-anode 7-segment display.
- Runs on the 125 MHz system clock.

Parameters:
- REFRESH_DIVIDE, 31250: CLK cycles per digit slot (4 kHz digit rate, 1 kHz full-frame refresh at 125 MHz).
- SIGNED_MODE, 1: 1 = input is two's complement (-128..127); 0 = unsigned (0..255).

Ports:
- CLK  in  1  125 MHz system clock
- RESET_N  in  1  asynchronous active-low reset
- DATA_IN  in  8  received byte from the SPI controller (MISO_DATA)
- DATA_VALID  in  1  level flag from the SPI controller; may stay high for thousands of cycles
- SEG  out  7  segment drive {g,f,e,d,c,b,a}, active-low
- AN  out  4  digit enables, active-low; AN[3] is the leftmost digit
- DP  out  1  decimal point, active-low; constant 1 (off)
- BUSY  out  1  high while the FSM is in CONVERT or LOAD
- UPDATED  out  1  one-cycle pulse when the display registers take a new value

Behaviour:
- Reset (async assert, sync release):
  - Outputs: SEG=7'h7F, AN=4'hF, DP=1, BUSY=0, UPDATED=0.
  - Internal: display value 0, FSM IDLE, scan index 0, refresh counter 0, pending flag 0, DATA_VALID history register 0.
  - Reset mid-conversion abandons the conversion; no UPDATED pulse.
- Capture:
  - DATA_VALID is registered into DV_Q. Capture edge = DATA_VALID & ~DV_Q. A level held high yields exactly one capture.
- FSM states: IDLE, CONVERT, LOAD.
  - IDLE → CONVERT on a capture edge. On that edge:
    - SIGNED_MODE=1: sign = DATA_IN[7], magnitude = |DATA_IN| as 8-bit unsigned (0x80 gives 128).
    - SIGNED_MODE=0: sign = 0, magnitude = DATA_IN.
    - BCD register (12 bits) cleared; iteration counter set to 8.
  - CONVERT, each cycle, 8 cycles total: for each BCD nibble, add 3 if it is ≥5; then shift {BCD, magnitude} left by 1; decrement the counter. After the 8th iteration go to LOAD.
  - LOAD, one cycle:
    - Display regs ← {sign, hundreds, tens, units}; UPDATED=1 for this cycle.
    - If the pending flag is set: load the pending byte as in IDLE, clear the flag, go to CONVERT.
    - Otherwise go to IDLE.
- Latency: a capture edge at clock k produces the UPDATED pulse and new display regs at clock k+9. The new value is visible on SEG from the next digit slot of the matching digit.
- Capture edge while in CONVERT or LOAD: the byte goes to the pending register and the pending flag is set. Further edges overwrite it (last wins). A capture edge in the same cycle that LOAD consumes the pending byte becomes the new pending byte.
- Scan:
  - The refresh counter counts 0..REFRESH_DIVIDE-1. On wrap, the scan index increments mod 4.
  - SEG and AN are registered and change on the same edge. Exactly one AN bit is low at any time after the first wrap; before the first wrap AN=4'hF.
- Digit content:
  - AN[0]: units, always shown.
  - AN[1]: tens; blank if hundreds=0 and tens=0.
  - AN[2]: hundreds; blank if 0.
  - AN[3]: '-' if sign=1, else blank. Always blank when SIGNED_MODE=0.
- Encoding (active-low, 7'h values):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10
  - minus=3F, blank=7F
- Display regs change only in LOAD, so the scan never shows a partially converted value.

Test Plan:
- Reset, then DATA_IN=8'h85 with DATA_VALID held high for 2000 cycles, SIGNED_MODE=1 → exactly one UPDATED pulse, 9 clocks after the capture edge. Over 4 slots AN[3..0] show SEG 3F, 79, 24, 30 ("-123").
- DATA_IN=8'h80 → SEG 3F, 79, 24, 00 ("-128"). DATA_IN=8'hFF → 3F, 7F, 7F, 79 ("-  1").
- DATA_IN=8'h07 → 7F, 7F, 7F, 78. DATA_IN=8'h00 → 7F, 7F, 7F, 40 (leading-zero blanking).
- SIGNED_MODE=0, DATA_IN=8'hFF → 7F, 24, 12, 12 ("255"); AN[3] slot is never 3F.
- Capture 8'h0C, then toggle DATA_VALID to capture 8'h22 and 8'h63 within the next 5 cycles → two UPDATED pulses, 9 cycles apart. Final display shows "99" (7F, 7F, 10, 10). 8'h22 is never displayed.
- RESET_N asserted during CONVERT → outputs immediately SEG=7F, AN=F, BUSY=0. After release, no UPDATED pulse occurs until a new DATA_VALID rising edge.
